// File: rtl/rti_core.sv
// Real-time input capture core: timestamps masked input changes into a 128-bit FWFT FIFO.
// Optional RTI_CORE_INPUT_SYNC_EN adds a 2-flop input synchronizer with timestamp compensation.
module rti_core #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     auto_start,
  input  logic [63:0]              counter,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [WIDTH-1:0]         mask,
  input  logic                     read,
  output logic [127:0]             rti_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     event_detected,
  output logic                     overflow_error,
  output logic [127:0]             overflow_error_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] sample;
  logic [63:0]      timestamp;

`ifdef RTI_CORE_INPUT_SYNC_EN
  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= data_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign sample = sync2_reg;
  // Report the counter at the edge where the change entered the first flop.
  assign timestamp = counter - 64'd2;
`else
  assign sample    = data_in;
  assign timestamp = counter;
`endif

  logic [WIDTH-1:0] prev_reg;
  logic [31:0]      seq_reg;
  logic [31:0]      data32;
  logic [127:0]     entry;
  logic             hit;
  logic             pop;
  logic             push;
  logic             drop;
  logic             is_full;

  logic [127:0]     mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [127:0]     rti_out_reg;
  logic             head_load;
  logic             head_bypass;

  logic             event_detected_reg;
  logic             overflow_error_reg;
  logic [127:0]     overflow_error_data_reg;

  always_comb begin
    data32 = '0;
    data32[WIDTH-1:0] = sample;
  end

  assign entry   = {seq_reg, timestamp, data32};
  assign hit     = auto_start && (((sample ^ prev_reg) & mask) != '0);
  assign is_full = (count_reg == CW'(DEPTH));
  assign pop     = read && (count_reg != '0) && !flush;
  assign push    = hit && !flush && (!is_full || pop);
  assign drop    = hit && !flush && !push;

  assign rd_ptr_next = rd_ptr_reg + AW'(pop);
  assign count_next  = count_reg + CW'(push) - CW'(pop);

  // The head register reloads only when the head entry changes; the freshly
  // pushed word is forwarded when it becomes the head on this same edge.
  assign head_load   = (count_next != '0) && (pop || (count_reg == '0));
  assign head_bypass = push && (rd_ptr_next == wr_ptr_reg);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      rti_out_reg <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (head_load) begin
        rti_out_reg <= head_bypass ? entry : mem[rd_ptr_next];
      end
    end
  end

  // History and sequence keep running through flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg                <= '0;
      seq_reg                 <= '0;
      event_detected_reg      <= 1'b0;
      overflow_error_reg      <= 1'b0;
      overflow_error_data_reg <= '0;
    end else begin
      prev_reg           <= sample;
      seq_reg            <= seq_reg + 32'(hit);
      event_detected_reg <= hit;
      overflow_error_reg <= drop;
      if (drop) begin
        overflow_error_data_reg <= entry;
      end
    end
  end

  assign rti_out             = rti_out_reg;
  assign empty               = (count_reg == '0);
  assign full                = is_full;
  assign count               = count_reg;
  assign event_detected      = event_detected_reg;
  assign overflow_error      = overflow_error_reg;
  assign overflow_error_data = overflow_error_data_reg;

endmodule

// File: tb/tb_rti_core.sv
// Bench for rti_core (DEPTH=4): queue-based reference model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_rti_core;
  localparam int W = 32;
  localparam int D = 4;
  localparam int CW = $clog2(D) + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush;
  logic           auto_start;
  logic [63:0]    counter;
  logic [W-1:0]   data_in;
  logic [W-1:0]   mask;
  logic           read;
  logic [127:0]   rti_out;
  logic           empty;
  logic           full;
  logic [CW-1:0]  count;
  logic           event_detected;
  logic           overflow_error;
  logic [127:0]   overflow_error_data;

  always #5 clk = ~clk;

  rti_core #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .flush(flush), .auto_start(auto_start),
    .counter(counter), .data_in(data_in), .mask(mask), .read(read),
    .rti_out(rti_out), .empty(empty), .full(full), .count(count),
    .event_detected(event_detected), .overflow_error(overflow_error),
    .overflow_error_data(overflow_error_data)
  );

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of entries plus the event rules.
  logic [127:0] mq[$];
  logic [31:0]  m_seq;
  logic [W-1:0] m_prev;
  logic         m_ev;
  logic         m_ovf;
  logic [127:0] m_ovfd;
  logic [127:0] m_head;

  always @(posedge clk) begin
    logic [127:0] e;
    logic ev, popped;
    int sz;
    if (reset) begin
      mq.delete();
      m_seq = 0; m_prev = 0; m_ev = 0; m_ovf = 0; m_ovfd = 0; m_head = 0;
    end else begin
      ev = auto_start && (((data_in ^ m_prev) & mask) != 0);
      e = {m_seq, counter, data_in};
      m_ev = ev;
      m_ovf = 0;
      if (flush) begin
        mq.delete();
      end else begin
        sz = mq.size();
        popped = read && (sz > 0);
        if (popped) void'(mq.pop_front());
        if (ev) begin
          if (sz < D || popped) mq.push_back(e);
          else begin m_ovf = 1; m_ovfd = e; end
        end
      end
      if (ev) m_seq = m_seq + 1;
      m_prev = data_in;
      if (mq.size() > 0) m_head = mq[0];
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("empty", 128'(empty), 128'(mq.size() == 0));
      chk("full", 128'(full), 128'(mq.size() == D));
      chk("count", 128'(count), 128'(mq.size()));
      chk("rti_out", rti_out, m_head);
      chk("event_detected", 128'(event_detected), 128'(m_ev));
      chk("overflow_error", 128'(overflow_error), 128'(m_ovf));
      chk("overflow_error_data", overflow_error_data, m_ovfd);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    counter = counter + 64'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1; data_in = '0; read = 1'b0; flush = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic pop_one(input logic [31:0] exp_seq);
    chk("pop_head_seq", 128'(rti_out[127:96]), 128'(exp_seq));
    $display("pop seq=%0d ts=%0h data=%0h", rti_out[127:96], rti_out[95:32], rti_out[31:0]);
    read = 1'b1;
    step();
    read = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; auto_start = 1'b0; counter = 64'h0;
    data_in = '0; mask = '0; read = 1'b0;
    step();
    started = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_empty", 128'(empty), 128'd1);
    chk("reset_count", 128'(count), 128'd0);
    chk("reset_rti_out", rti_out, 128'd0);

    // Basic capture
    auto_start = 1'b1; mask = 32'hFFFF_FFFF; data_in = 32'h0;
    step();
    counter = 64'h100; data_in = 32'hA5;
    step();
    chk("basic_entry", rti_out, {32'd0, 64'h100, 32'hA5});
    chk("basic_empty", 128'(empty), 128'd0);
    chk("basic_event", 128'(event_detected), 128'd1);
    pop_one(32'd0);
    chk("basic_drained", 128'(empty), 128'd1);

    // Masking
    do_reset();
    mask = 32'h0F; data_in = 32'hF0;
    step();
    chk("mask_no_event", 128'(empty), 128'd1);
    counter = 64'h200; data_in = 32'hF3;
    step();
    chk("mask_entry", rti_out, {32'd0, 64'h200, 32'hF3});
    pop_one(32'd0);

    // Disabled capture
    mask = 32'hFFFF_FFFF; auto_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = 32'h1000 + 32'(i);
      step();
    end
    auto_start = 1'b1;
    step(); step();
    chk("disabled_empty", 128'(empty), 128'd1);
    chk("disabled_event", 128'(event_detected), 128'd0);

    // Overflow with DEPTH=4
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      data_in = 32'(i);
      step();
    end
    chk("ovf_full", 128'(full), 128'd1);
    chk("ovf_pulse", 128'(overflow_error), 128'd1);
    chk("ovf_seq", 128'(overflow_error_data[127:96]), 128'd4);
    chk("ovf_data", 128'(overflow_error_data[31:0]), 128'd5);
    step();
    chk("ovf_one_cycle", 128'(overflow_error), 128'd0);
    for (int i = 0; i < 4; i++) pop_one(32'(i));
    chk("ovf_drained", 128'(empty), 128'd1);

    // Full boundary with concurrent pop
    for (int i = 6; i <= 9; i++) begin
      data_in = 32'(i);
      step();
    end
    chk("fullpop_pre_full", 128'(full), 128'd1);
    data_in = 32'd10; read = 1'b1;
    step();
    read = 1'b0;
    chk("fullpop_count", 128'(count), 128'd4);
    chk("fullpop_no_ovf", 128'(overflow_error), 128'd0);
    chk("fullpop_head", 128'(rti_out[127:96]), 128'd6);

    // Flush coinciding with an event
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      data_in = 32'(i);
      step();
    end
    chk("flush_pre_count", 128'(count), 128'd3);
    data_in = 32'd4; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_empty", 128'(empty), 128'd1);
    chk("flush_count", 128'(count), 128'd0);
    chk("flush_no_ovf", 128'(overflow_error), 128'd0);
    counter = 64'h300; data_in = 32'd5;
    step();
    chk("flush_next_entry", rti_out, {32'd4, 64'h300, 32'd5});
    chk("flush_next_count", 128'(count), 128'd1);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rti_core.md
# rti_core

Real-time input (RTI) core: the capture-side counterpart of the timed output core. It watches a parallel input bus and timestamps every masked change against the shared 64-bit timeline counter. Each event is stored as a 128-bit entry in an internal FIFO, using the same word layout the output core consumes. Downstream logic or the CPU bridge drains the FIFO with a first-word-fall-through read strobe.

## Interface
Parameters:
- WIDTH, 32: input bus width, 1..32.
- DEPTH, 512: FIFO entries, power of 2, ≥4.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous FIFO clear; sequence count and edge history kept.
- auto_start  in  1  capture enable.
- counter  in  64  timeline counter, same domain as clk.
- data_in  in  WIDTH  monitored inputs.
- mask  in  WIDTH  1 = bit participates in change detection.
- read  in  1  pop strobe.
- rti_out  out  128  head entry, valid while empty=0.
- empty  out  1  FIFO empty.
- full  out  1  FIFO holds DEPTH entries.
- count  out  $clog2(DEPTH)+1  occupancy.
- event_detected  out  1  one-cycle pulse per detected event.
- overflow_error  out  1  one-cycle pulse, event dropped.
- overflow_error_data  out  128  last dropped entry.

Clocking and reset: one clock; reset is synchronous and active-high.

## Operation
- Entry format:
  - [127:96]: seq, 32-bit event number, wraps at 2^32.
  - [95:32]: timestamp.
  - [31:0]: data_in, zero-extended.
- History register prev updates to the sampled input every cycle, regardless of auto_start, so enabling capture never fires on stale history.
- Event condition at an edge: auto_start && ((sample ^ prev) & mask) != 0.
- On an event:
  - Form entry {seq, counter, sample}, where sample is the full value, unmasked bits included.
  - seq increments by 1, whether or not the entry is stored.
  - event_detected pulses.
- Write decision:
  - Entry is written if FIFO is not full, or if full and read=1 on the same edge (pop and push together).
  - Otherwise the entry is dropped: overflow_error pulses and overflow_error_data latches the entry.
- Read:
  - read=1 with empty=0 pops the head.
  - read=1 with empty=1 is ignored; no state change.
- Simultaneous push and pop on a non-empty FIFO: count unchanged.
- Push onto an empty FIFO with read=1: the read is ignored and the entry is stored.
- flush:
  - Pointers and count go to 0.
  - An event on the same edge is discarded silently: no overflow_error; seq still increments.
- reset, including mid-operation: FIFO emptied, seq=0, prev=0, all registered outputs at reset values on the next cycle.

## Timing
- Reset values: empty=1, full=0, count=0, event_detected=0, overflow_error=0, overflow_error_data=0, rti_out=0.
- Timestamp = counter value present at the edge that samples the change (without the synchronizer).
- Event at edge N: event_detected high during cycle N..N+1; empty=0 and rti_out valid from just after edge N (1-cycle latency).
- Pop at edge N: next entry on rti_out after edge N; rti_out holds its last value when empty.
- full asserts after the edge that writes entry DEPTH and deasserts after the first pop.
- overflow_error is high for exactly the one cycle following the dropping edge.

## Configuration
RTI_CORE_INPUT_SYNC_EN
- Defined:
  - data_in passes through a 2-flop synchronizer before detection; event latency becomes 3 cycles.
  - Stored timestamp = counter − 2 (mod 2^64), so it equals the counter at the edge where the change entered the first flop.
  - prev is reset through the synchronizer chain.
- Undefined: data_in is used directly, timestamp = counter, 1-cycle latency.

## Test plan
- Basic capture: reset, auto_start=1, mask=FFFFFFFF, counter=0x100 when data_in goes 0→0xA5 -> one entry {0, 0x100, 0xA5}; empty=0 one cycle later.
- Masking: mask=0x0F, data_in 0x00→0xF0 then 0xF0→0xF3 -> only the second change is captured, entry data 0xF3, seq=0.
- Disabled capture: auto_start=0 while data_in toggles, then auto_start=1 with data_in steady -> no entries, event_detected stays 0.
- Overflow: DEPTH=4, 5 events, no read -> full=1, overflow_error pulses once with data seq=4; after 4 reads FIFO holds seq 0..3 in order.
- Full boundary with concurrent pop: full FIFO, event and read on same edge -> count stays 4, no overflow_error, head becomes seq 1.
- Flush: 3 entries, flush on the same edge as an event -> empty=1, count=0, no overflow_error; the next event carries seq=4.
